// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl
//   Framed serial-in/parallel-out receiver controller. A start strobe begins a
//   WIDTH-bit capture (first bit lands in p_out[0]). The completed word is held
//   on p_out under a valid/ready handshake. A start that arrives while a word
//   is still pending is dropped and recorded in the sticky overrun flag.
//
//   Optional feature macro: SIPO_RX_CTRL_PARITY_EN
//     defined   - each frame carries one trailing even-parity bit; parity_err
//                 is registered alongside p_out.
//     undefined - no parity state; parity_err is tied to 0.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   s_in       in   serial data, sampled on rising clk
//   start      in   frame strobe, concurrent with the first data bit
//   out_ready  in   consumer accepts p_out while out_valid is high
//   p_out      out  completed word (WIDTH bits)
//   out_valid  out  p_out holds an unconsumed word
//   busy       out  frame capture in progress
//   overrun    out  sticky: a start was dropped while a word was pending
//   parity_err out  parity result for the word on p_out
module sipo_rx_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_in,
    input  logic             start,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
`ifdef SIPO_RX_CTRL_PARITY_EN
        PARITY = 2'd2,
`endif
        HOLD   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] p_out_q, p_out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] sr_shift;

    // New bit enters at the MSB; written as a shifted concatenation so that
    // the outgoing LSB is part of the expression rather than silently dropped.
    assign sr_shift = WIDTH'({s_in, sr_q} >> 1);

`ifdef SIPO_RX_CTRL_PARITY_EN
    logic par_q, par_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            p_out_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SIPO_RX_CTRL_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            p_out_q   <= p_out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
`ifdef SIPO_RX_CTRL_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        p_out_d   = p_out_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
`ifdef SIPO_RX_CTRL_PARITY_EN
        par_d     = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = sr_shift;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                // start is deliberately ignored here
                sr_d  = sr_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
`ifdef SIPO_RX_CTRL_PARITY_EN
                    state_d = PARITY;
`else
                    p_out_d = sr_shift;
                    valid_d = 1'b1;
                    state_d = HOLD;
`endif
                end
            end

`ifdef SIPO_RX_CTRL_PARITY_EN
            PARITY: begin
                // sr already holds the full data word; s_in is the parity bit
                p_out_d = sr_q;
                par_d   = ^{sr_q, s_in};
                valid_d = 1'b1;
                state_d = HOLD;
            end
`endif

            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (start) begin
                        // consume and begin the next frame on the same edge
                        sr_d    = sr_shift;
                        cnt_d   = CW'(1);
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start) begin
                    overrun_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

`ifdef SIPO_RX_CTRL_PARITY_EN
        busy_d = (state_d == SHIFT) || (state_d == PARITY);
`else
        busy_d = (state_d == SHIFT);
`endif
    end

    assign p_out     = p_out_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
`ifdef SIPO_RX_CTRL_PARITY_EN
    assign parity_err = par_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
module tb_sipo_rx_ctrl;

    localparam int unsigned W = 4;
`ifdef SIPO_RX_CTRL_PARITY_EN
    localparam int unsigned NEDGE = W + 1;
`else
    localparam int unsigned NEDGE = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         s_in;
    logic         start;
    logic         out_ready;
    logic [W-1:0] p_out;
    logic         out_valid;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    int errors = 0;
    int checks = 0;

    sipo_rx_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_in       (s_in),
        .start      (start),
        .out_ready  (out_ready),
        .p_out      (p_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock edge; outputs are then sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full frame: start with bit 0, optional start re-pulse at bit 2,
    // trailing parity bit when compiled in. busy/out_valid checked per edge.
    task automatic send(input logic [3:0] d, input logic par_bit, input logic mid_start);
        for (int unsigned i = 0; i < NEDGE; i++) begin
            if (i < W) begin
                s_in  = d[i];
                start = (i == 0) ? 1'b1 : ((i == 2) ? mid_start : 1'b0);
            end else begin
                s_in  = par_bit;
                start = 1'b0;
            end
            tick();
            if (i < NEDGE - 1) begin
                chk("busy_mid", {31'd0, busy}, 32'd1);
                chk("valid_mid", {31'd0, out_valid}, 32'd0);
            end else begin
                chk("busy_end", {31'd0, busy}, 32'd0);
                chk("valid_end", {31'd0, out_valid}, 32'd1);
            end
        end
        start = 1'b0;
        s_in  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_in = 1'b0; start = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_pout", {28'd0, p_out}, 32'h0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        @(negedge clk); rst = 1'b0;
        tick();

        // reset mid-frame after 2 bits
        s_in = 1'b1; start = 1'b1; tick();
        s_in = 1'b0; start = 1'b0; tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1; #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_pout", {28'd0, p_out}, 32'h0);
        tick();
        @(negedge clk); rst = 1'b0;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        send(4'b1101, 1'b1, 1'b0);
        chk("after_rst_pout", {28'd0, p_out}, 32'hD);
        chk("parity_ok", {31'd0, parity_err}, 32'd0);
        tick();
        chk("valid_one_cycle", {31'd0, out_valid}, 32'd0);
        chk("pout_held", {28'd0, p_out}, 32'hD);

        // basic frame again from IDLE
        send(4'b1101, 1'b1, 1'b0);
        chk("basic_pout", {28'd0, p_out}, 32'hD);
        tick();
        chk("basic_consumed", {31'd0, out_valid}, 32'd0);

        // stall and overrun
        out_ready = 1'b0;
        send(4'b0110, 1'b0, 1'b0);
        chk("stall_pout", {28'd0, p_out}, 32'h6);
        start = 1'b1; s_in = 1'b1; tick();
        start = 1'b0; s_in = 1'b0;
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        chk("ovr_pout", {28'd0, p_out}, 32'h6);
        chk("ovr_valid", {31'd0, out_valid}, 32'd1);
        chk("ovr_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1; tick();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);

        // back-to-back: first word left pending, second starts on transfer edge
        out_ready = 1'b0;
        send(4'b1101, 1'b1, 1'b0);
        chk("b2b_first", {28'd0, p_out}, 32'hD);
        out_ready = 1'b1;
        send(4'b1111, 1'b0, 1'b0);
        chk("b2b_second", {28'd0, p_out}, 32'hF);
        chk("b2b_ovr", {31'd0, overrun}, 32'd1);
        tick();
        chk("b2b_consumed", {31'd0, out_valid}, 32'd0);

        // start ignored during SHIFT (after fresh reset clears overrun)
        rst = 1'b1; tick();
        @(negedge clk); rst = 1'b0;
        tick();
        chk("ovr_cleared", {31'd0, overrun}, 32'd0);
        send(4'b0100, 1'b1, 1'b1);
        chk("midstart_pout", {28'd0, p_out}, 32'h4);
        chk("midstart_ovr", {31'd0, overrun}, 32'd0);
        tick();
        chk("midstart_idle", {31'd0, busy}, 32'd0);

`ifdef SIPO_RX_CTRL_PARITY_EN
        send(4'b1101, 1'b0, 1'b0);
        chk("parerr_pout", {28'd0, p_out}, 32'hD);
        chk("parerr_flag", {31'd0, parity_err}, 32'd1);
        tick();
        send(4'b1101, 1'b1, 1'b0);
        chk("parok_flag", {31'd0, parity_err}, 32'd0);
        tick();
`else
        chk("par_tied", {31'd0, parity_err}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
